regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between NREQ writeback requesters: ALU, multdiv and exception/status.
- Arbitrates round-robin and registers the winner.
- Drives a one-hot 32-bit write-enable vector plus write data into the 32x32 register file.
- Forwards the in-flight write to two read ports so same-cycle readers see the value being written.

---
 rtl/regfile_write_arbiter_pkg.sv | 30 +++
 rtl/regfile_write_arbiter_if.sv | 27 ++
 rtl/regfile_write_arbiter_rr_pick.sv | 31 +++
 rtl/regfile_write_arbiter.sv | 94 +++++++++
 tb/tb_regfile_write_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, payload type and enable decoder for the register-file write arbiter.
package regfile_write_arbiter_pkg;

   localparam int unsigned NREG = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned DW   = 32;

   localparam logic [RW-1:0] REG_ZERO = 5'd0;

   localparam int unsigned REQ_ALU     = 0;
   localparam int unsigned REQ_MULTDIV = 1;
   localparam int unsigned REQ_EXC     = 2;

   // One registered writeback: destination register and its data
   typedef struct packed {
      logic [RW-1:0] rd;
      logic [DW-1:0] data;
   } wb_s;

   // 5-to-32 enable decoder: one-hot on sel when en, else all zero
   function automatic logic [NREG-1:0] dec5to32(input logic en, input logic [RW-1:0] sel);
      logic [NREG-1:0] v;
      v = '0;
      if (en) begin
         v[sel] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus: per-requester valid/rd/data, one-hot ready back.
interface regfile_write_arbiter_if
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 3
) ();

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*RW-1:0] req_rd;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;

   modport master (
      output req_valid,
      output req_rd,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_rd,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational NREQ-way round-robin picker starting the search at ptr_i.
module regfile_write_arbiter_rr_pick #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   logic [PW-1:0] pos_c;

   // First valid requester at or after ptr, wrapping modulo NREQ
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      pos_c   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         pos_c = PW'((32'(ptr_i) + k) % NREQ);
         if (!any_o && valid_i[pos_c]) begin
            any_o          = 1'b1;
            grant_o[pos_c] = 1'b1;
            idx_o          = pos_c;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with read-port forwarding.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   hold,
   regfile_write_arbiter_if.slave req,
   input  logic [RW-1:0]          rd_a,
   input  logic [RW-1:0]          rd_b,
   output logic [NREG-1:0]        rf_we,
   output logic [DW-1:0]          rf_data,
   output logic                   fwd_a_valid,
   output logic                   fwd_b_valid,
   output logic [DW-1:0]          fwd_a_data,
   output logic [DW-1:0]          fwd_b_data
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] pick_valid_c;
   logic [NREQ-1:0] grant_c;
   logic [PW-1:0]   gidx_c;
   logic            any_c;
   wb_s             sel_c;

   logic [PW-1:0]   ptr_q, ptr_d;
   logic            pend_q, pend_d;
   wb_s             wb_q, wb_d;

   // hold masks every request so no grant can be issued
   assign pick_valid_c = hold ? '0 : req.req_valid;

   regfile_write_arbiter_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .valid_i (pick_valid_c),
      .ptr_i   (ptr_q),
      .grant_o (grant_c),
      .idx_o   (gidx_c),
      .any_o   (any_c)
   );

   assign req.req_ready = grant_c;

   // Mux the granted requester's destination and data
   always_comb begin
      sel_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_c[i]) begin
            sel_c.rd   = req.req_rd[RW*i +: RW];
            sel_c.data = req.req_data[DW*i +: DW];
         end
      end
   end

   // Next state: pointer past the winner, capture the write, pending for one cycle
   always_comb begin
      ptr_d  = ptr_q;
      pend_d = any_c;
      wb_d   = wb_q;
      if (any_c) begin
         wb_d  = sel_c;
         ptr_d = (gidx_c == PW'(NREQ - 1)) ? '0 : gidx_c + PW'(1);
      end
   end

   // State registers; async reset drops any in-flight write
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q  <= '0;
         pend_q <= 1'b0;
         wb_q   <= '0;
      end else begin
         ptr_q  <= ptr_d;
         pend_q <= pend_d;
         wb_q   <= wb_d;
      end
   end

   // r0 writes are accepted upstream but never enabled here
   assign rf_we   = dec5to32(pend_q && (wb_q.rd != REG_ZERO), wb_q.rd);
   assign rf_data = wb_q.data;

   // Forward the in-flight write to same-cycle readers
   assign fwd_a_valid = pend_q && (rd_a == wb_q.rd) && (wb_q.rd != REG_ZERO);
   assign fwd_b_valid = pend_q && (rd_b == wb_q.rd) && (wb_q.rd != REG_ZERO);
   assign fwd_a_data  = wb_q.data;
   assign fwd_b_data  = wb_q.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            hold  = 1'b0;
   logic [4:0]      rd_a  = '0;
   logic [4:0]      rd_b  = '0;
   logic [31:0]     rf_we;
   logic [31:0]     rf_data;
   logic            fwd_a_valid, fwd_b_valid;
   logic [31:0]     fwd_a_data, fwd_b_data;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   regfile_write_arbiter_if #(.NREQ(3)) rif ();

   regfile_write_arbiter #(.NREQ(3)) dut (
      .clock       (clock),
      .reset       (reset),
      .hold        (hold),
      .req         (rif.slave),
      .rd_a        (rd_a),
      .rd_b        (rd_b),
      .rf_we       (rf_we),
      .rf_data     (rf_data),
      .fwd_a_valid (fwd_a_valid),
      .fwd_b_valid (fwd_b_valid),
      .fwd_a_data  (fwd_a_data),
      .fwd_b_data  (fwd_b_data)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
      rif.req_rd[5*i +: 5]    = rd;
      rif.req_data[32*i +: 32] = data;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      rif.req_valid = '0;
      rif.req_rd    = '0;
      rif.req_data  = '0;
      reset = 1'b0;
      tick();
      tick();
      total++; if (rf_we !== 32'h0) begin bad++; $display("FAIL reset_we got=%h want=%h", rf_we, 32'h0); end
      total++; if (rf_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=%h", rf_data, 32'h0); end
      total++; if (fwd_a_valid !== 1'b0 || fwd_b_valid !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b%b want=00", fwd_a_valid, fwd_b_valid); end
      reset = 1'b1;
   endtask

   task automatic test_single();
      set_req(0, 5'd5, 32'hDEADBEEF);
      rif.req_valid = 3'b001;
      #1;
      total++; if (rif.req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b want=001", rif.req_ready); end
      tick();
      rif.req_valid = 3'b000;
      total++; if (rf_we !== 32'h0000_0020) begin bad++; $display("FAIL single_we got=%h want=%h", rf_we, 32'h20); end
      total++; if (rf_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h want=%h", rf_data, 32'hDEADBEEF); end
      tick();
      total++; if (rf_we !== 32'h0) begin bad++; $display("FAIL single_we_clear got=%h want=0", rf_we); end
      total++; if (rf_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data_hold got=%h want=%h", rf_data, 32'hDEADBEEF); end
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_g;
      logic [31:0] exp_we;
      do_reset();
      set_req(0, 5'd1, 32'h0000_0100);
      set_req(1, 5'd2, 32'h0000_0101);
      set_req(2, 5'd3, 32'h0000_0102);
      rif.req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         exp_g  = 3'(1 << (c % 3));
         exp_we = 32'h1 << ((c % 3) + 1);
         #1;
         total++; if (rif.req_ready !== exp_g) begin bad++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, rif.req_ready, exp_g); end
         tick();
         total++; if (rf_we !== exp_we) begin bad++; $display("FAIL rr_we c=%0d got=%h want=%h", c, rf_we, exp_we); end
         total++; if (rf_data !== 32'h100 + 32'(c % 3)) begin bad++; $display("FAIL rr_data c=%0d got=%h want=%h", c, rf_data, 32'h100 + 32'(c % 3)); end
      end
      rif.req_valid = 3'b000;
      tick();
   endtask

   // ptr = 0 on entry
   task automatic test_reg0();
      set_req(1, 5'd0, 32'h0000_1234);
      rif.req_valid = 3'b010;
      #1;
      total++; if (rif.req_ready !== 3'b010) begin bad++; $display("FAIL r0_ready got=%b want=010", rif.req_ready); end
      tick();
      rif.req_valid = 3'b000;
      rd_a = 5'd0;
      #1;
      total++; if (rf_we !== 32'h0) begin bad++; $display("FAIL r0_we got=%h want=0", rf_we); end
      total++; if (fwd_a_valid !== 1'b0) begin bad++; $display("FAIL r0_fwd got=%b want=0", fwd_a_valid); end
      set_req(0, 5'd10, 32'h0);
      set_req(1, 5'd11, 32'h0);
      set_req(2, 5'd12, 32'h0);
      rif.req_valid = 3'b111;
      #1;
      total++; if (rif.req_ready !== 3'b100) begin bad++; $display("FAIL r0_ptr got=%b want=100", rif.req_ready); end
      rif.req_valid = 3'b000;
      tick();
   endtask

   // ptr = 2 on entry
   task automatic test_hold();
      set_req(0, 5'd7, 32'h0000_0077);
      rif.req_valid = 3'b001;
      #1;
      total++; if (rif.req_ready !== 3'b001) begin bad++; $display("FAIL hold_pre_ready got=%b want=001", rif.req_ready); end
      tick();
      hold = 1'b1;
      rif.req_valid = 3'b111;
      #1;
      total++; if (rf_we !== 32'h0000_0080) begin bad++; $display("FAIL hold_inflight_we got=%h want=%h", rf_we, 32'h80); end
      for (int c = 0; c < 3; c++) begin
         total++; if (rif.req_ready !== 3'b000) begin bad++; $display("FAIL hold_ready c=%0d got=%b want=000", c, rif.req_ready); end
         tick();
         total++; if (rf_we !== 32'h0) begin bad++; $display("FAIL hold_we c=%0d got=%h want=0", c, rf_we); end
      end
      hold = 1'b0;
      #1;
      total++; if (rif.req_ready !== 3'b010) begin bad++; $display("FAIL hold_resume got=%b want=010", rif.req_ready); end
      rif.req_valid = 3'b000;
      tick();
   endtask

   // ptr = 1 on entry
   task automatic test_forward();
      set_req(2, 5'd17, 32'hA5A5A5A5);
      rif.req_valid = 3'b100;
      #1;
      total++; if (rif.req_ready !== 3'b100) begin bad++; $display("FAIL fwd_ready got=%b want=100", rif.req_ready); end
      tick();
      rif.req_valid = 3'b000;
      rd_a = 5'd17;
      rd_b = 5'd17;
      #1;
      total++; if (fwd_a_valid !== 1'b1 || fwd_b_valid !== 1'b1) begin bad++; $display("FAIL fwd_both got=%b%b want=11", fwd_a_valid, fwd_b_valid); end
      total++; if (fwd_a_data !== 32'hA5A5A5A5 || fwd_b_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL fwd_data got=%h/%h want=%h", fwd_a_data, fwd_b_data, 32'hA5A5A5A5); end
      rd_b = 5'd16;
      #1;
      total++; if (fwd_b_valid !== 1'b0 || fwd_a_valid !== 1'b1) begin bad++; $display("FAIL fwd_b_miss got=%b%b want=10", fwd_a_valid, fwd_b_valid); end
      tick();
      total++; if (fwd_a_valid !== 1'b0) begin bad++; $display("FAIL fwd_expire got=%b want=0", fwd_a_valid); end
   endtask

   // ptr = 0 on entry
   task automatic test_reset_mid();
      set_req(1, 5'd9, 32'h0000_0099);
      rif.req_valid = 3'b010;
      rd_a = 5'd9;
      tick();
      rif.req_valid = 3'b000;
      total++; if (rf_we !== 32'h0000_0200) begin bad++; $display("FAIL mid_we_before got=%h want=%h", rf_we, 32'h200); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (rf_we !== 32'h0) begin bad++; $display("FAIL mid_we_drop got=%h want=0", rf_we); end
      total++; if (rf_data !== 32'h0 || fwd_a_valid !== 1'b0) begin bad++; $display("FAIL mid_state got=%h/%b want=0/0", rf_data, fwd_a_valid); end
      tick();
      reset = 1'b1;
      set_req(0, 5'd20, 32'h0);
      set_req(2, 5'd22, 32'h0);
      rif.req_valid = 3'b111;
      #1;
      total++; if (rif.req_ready !== 3'b001) begin bad++; $display("FAIL mid_ptr got=%b want=001", rif.req_ready); end
      rif.req_valid = 3'b000;
      tick();
      total++; if (rf_we !== 32'h0) begin bad++; $display("FAIL mid_no_r9 got=%h want=0", rf_we); end
   endtask

   // ptr = 0 on entry
   task automatic test_same_rd();
      set_req(0, 5'd4, 32'h0000_000A);
      set_req(1, 5'd4, 32'h0000_000B);
      rif.req_valid = 3'b011;
      #1;
      total++; if (rif.req_ready !== 3'b001) begin bad++; $display("FAIL same_first got=%b want=001", rif.req_ready); end
      tick();
      total++; if (rif.req_ready !== 3'b010) begin bad++; $display("FAIL same_second got=%b want=010", rif.req_ready); end
      total++; if (rf_we !== 32'h10 || rf_data !== 32'hA) begin bad++; $display("FAIL same_w1 got=%h/%h want=10/a", rf_we, rf_data); end
      tick();
      rif.req_valid = 3'b000;
      total++; if (rf_we !== 32'h10 || rf_data !== 32'hB) begin bad++; $display("FAIL same_w2 got=%h/%h want=10/b", rf_we, rf_data); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_reg0();
      test_hold();
      test_forward();
      test_reset_mid();
      test_same_rd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
